spi_eeprom_responder: RTL

Synthesizable SPI EEPROM target: the device side of the 0x03-read SPI EEPROM link our controller drives. It oversamples SCLK/CS/MOSI on the system clock, decodes READ (0x03) and WRITE (0x02) with a 24-bit address, and serves bytes from, or stores bytes to, an on-chip byte memory through a simple request port. Used as a loopback target in simulation and as an EEPROM emulator on silicon.

---
 rtl/spi_eeprom_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 EEPROM target that serves READ (0x03) and
// WRITE (0x02) commands with a 24-bit address against an external byte memory.
// SPI pins are oversampled on clk; nothing here is clocked by SCLK.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   IN_sclk/IN_cs/IN_mosi    SPI pins from the initiator (CS active low)
//   OUT_miso/OUT_misoOE      target data and its output enable
//   OUT_memAddr              byte address for read/write strobes
//   OUT_memRead/IN_memData   read strobe; data valid the cycle after the strobe
//   OUT_memWrite/WData       write strobe and data
//   OUT_busy                 synchronized CS is low
//   OUT_cmdErr               pulse on an unsupported command byte
module spi_eeprom_responder #(
  parameter int unsigned MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_sclk,
  input  logic              IN_cs,
  input  logic              IN_mosi,
  output logic              OUT_miso,
  output logic              OUT_misoOE,
  output logic [MEM_AW-1:0] OUT_memAddr,
  output logic              OUT_memRead,
  input  logic [7:0]        IN_memData,
  output logic              OUT_memWrite,
  output logic [7:0]        OUT_memWData,
  output logic              OUT_busy,
  output logic              OUT_cmdErr
);

  // Only the low MEM_AW address bits are kept; older bits fall off the top.
  localparam int unsigned ShW = (MEM_AW > 8) ? MEM_AW - 1 : 7;
  localparam logic [MEM_AW-1:0] AddrOne = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRdData, StWrData, StIgnore} state_e;

  state_e r_state, w_state_next;

  logic r_sclk_m, r_sclk_s, r_sclk_p;
  logic r_cs_m, r_cs_s;
  logic r_mosi_m, r_mosi_s;

  logic [4:0]        r_bit_cnt;
  logic [ShW-1:0]    r_shift;
  logic [MEM_AW-1:0] r_addr;
  logic              r_is_read;
  logic [7:0]        r_buf;
  logic              r_buf_full;
  logic              r_rd_pend;
  logic [6:0]        r_tx;
  logic              r_miso, r_miso_oe, r_mem_rd, r_mem_wr, r_cmd_err;
  logic [7:0]        r_wdata;

  logic              w_rise, w_fall;
  logic [7:0]        w_byte;
  logic [MEM_AW-1:0] w_addr_word;
  logic              w_cmd_ok, w_cmd_done, w_addr_done, w_wr_done, w_busy;
  logic [7:0]        w_tx_byte;

  assign w_rise      = r_sclk_s & ~r_sclk_p;
  assign w_fall      = ~r_sclk_s & r_sclk_p;
  assign w_byte      = {r_shift[6:0], r_mosi_s};
  assign w_addr_word = {r_shift, r_mosi_s};
  // An empty prefetch buffer (never expected at legal SCLK rates) sends 0xFF.
  assign w_tx_byte   = r_buf_full ? r_buf : 8'hFF;

  // Pin synchronizers; CS idles high and SCLK low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_m <= 1'b0;
      r_sclk_s <= 1'b0;
      r_sclk_p <= 1'b0;
      r_cs_m   <= 1'b1;
      r_cs_s   <= 1'b1;
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
    end else begin
      r_sclk_m <= IN_sclk;
      r_sclk_s <= r_sclk_m;
      r_sclk_p <= r_sclk_s;
      r_cs_m   <= IN_cs;
      r_cs_s   <= r_cs_m;
      r_mosi_m <= IN_mosi;
      r_mosi_s <= r_mosi_m;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic; CS high wins over every edge event.
  always_comb begin
    w_state_next = r_state;
    if (r_cs_s) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:  w_state_next = StCmd;
        StCmd:   if (w_cmd_done) w_state_next = w_cmd_ok ? StAddr : StIgnore;
        StAddr:  if (w_addr_done) w_state_next = r_is_read ? StRdData : StWrData;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Output/event decode
  always_comb begin
    w_cmd_ok    = (w_byte == 8'h03) || (w_byte == 8'h02);
    w_cmd_done  = (r_state == StCmd) && w_rise && (r_bit_cnt == 5'd7);
    w_addr_done = (r_state == StAddr) && w_rise && (r_bit_cnt == 5'd23);
    w_wr_done   = (r_state == StWrData) && w_rise && (r_bit_cnt == 5'd7);
    w_busy      = ~r_cs_s;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= 5'd0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_is_read  <= 1'b0;
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_tx       <= 7'h00;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_wdata    <= 8'h00;
    end else begin
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_cmd_err <= 1'b0;
      if (r_cs_s) begin
        r_bit_cnt  <= 5'd0;
        r_shift    <= '0;
        r_miso_oe  <= 1'b0;
        r_buf_full <= 1'b0;
        r_rd_pend  <= 1'b0;
      end else begin
        r_rd_pend <= r_mem_rd;
        case (r_state)
          StIdle: r_bit_cnt <= 5'd0;
          StCmd: begin
            if (w_rise) begin
              r_shift <= {r_shift[ShW-2:0], r_mosi_s};
              if (w_cmd_done) begin
                r_bit_cnt <= 5'd0;
                r_is_read <= (w_byte == 8'h03);
                r_cmd_err <= ~w_cmd_ok;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          StAddr: begin
            if (w_rise) begin
              r_shift <= {r_shift[ShW-2:0], r_mosi_s};
              if (w_addr_done) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= w_addr_word;
                r_mem_rd  <= r_is_read;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          StRdData: begin
            // Read data arrives the cycle after the strobe cycle.
            if (r_rd_pend) begin
              r_buf      <= IN_memData;
              r_buf_full <= 1'b1;
              r_addr     <= r_addr + AddrOne;
            end
            if (w_fall) begin
              r_miso_oe <= 1'b1;
              r_bit_cnt <= (r_bit_cnt[2:0] == 3'd7) ? 5'd0 : r_bit_cnt + 5'd1;
              if (r_bit_cnt[2:0] == 3'd0) begin
                r_tx       <= w_tx_byte[6:0];
                r_miso     <= w_tx_byte[7];
                r_buf_full <= 1'b0;
                r_mem_rd   <= 1'b1;
              end else begin
                r_tx   <= {r_tx[5:0], 1'b0};
                r_miso <= r_tx[6];
              end
            end
          end
          StWrData: begin
            if (r_mem_wr) r_addr <= r_addr + AddrOne;
            if (w_rise) begin
              r_shift <= {r_shift[ShW-2:0], r_mosi_s};
              if (w_wr_done) begin
                r_bit_cnt <= 5'd0;
                r_mem_wr  <= 1'b1;
                r_wdata   <= w_byte;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign OUT_miso     = r_miso;
  assign OUT_misoOE   = r_miso_oe;
  assign OUT_memAddr  = r_addr;
  assign OUT_memRead  = r_mem_rd;
  assign OUT_memWrite = r_mem_wr;
  assign OUT_memWData = r_wdata;
  assign OUT_busy     = w_busy;
  assign OUT_cmdErr   = r_cmd_err;

endmodule
